pipe_rate_pd_sequencer: RTL and testbench
=========================================

# pipe_rate_pd_sequencer

Sequences PIPE PowerDown and Rate changes for one link (all lanes share the PHY control signals). Sits between the LTSSM and the PHY, next to the PIPE TX/detect control logic. Accepts one configuration request at a time and quiesces the transmitter. Drives the new PowerDown and/or Rate values, then completes the PhyStatus handshake with a timeout. Reports done or error to the requester.

## Interface
Parameters:
- `ELECIDLE_SETTLE`, default 8: cycles TX is forced idle before PHY controls change; must be ≥1.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles waited for PhyStatus per handshake step; must be ≥2.

Ports:
- `pclk`  in  1  PIPE clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_rate`  in  3  target generation; valid values are 1, 2, 3.
- `req_powerdown`  in  4  target PowerDown; valid values are 0 (P0) and 2 (P1).
- `req_ready`  out  1  block idle, request can be accepted.
- `done`  out  1  one-cycle pulse, request completed.
- `error`  out  1  one-cycle pulse, request rejected or timed out.
- `busy`  out  1  sequencing in progress.
- `PhyStatus`  in  1  PHY completion pulse.
- `Rate`  out  2  PIPE Rate: 0 = Gen1, 1 = Gen2, 2 = Gen3.
- `PowerDown`  out  4  PIPE PowerDown.
- `TxElecIdle_force`  out  1  ORed into PHY TxElecIdle.

## Operation
Reset values:
- `Rate` = 0, `PowerDown` = 2.
- `TxElecIdle_force` = 1, `req_ready` = 1.
- `done` = `error` = `busy` = 0.
- State IDLE, counters 0.

States: IDLE, QUIESCE, APPLY_PD, WAIT_PD, APPLY_RATE, WAIT_RATE.

Acceptance:
- A request is accepted when `req_valid` && `req_ready` at a rising edge.
- Request values are latched on acceptance. Later input changes are ignored until the next acceptance.
- `req_ready` = 1 only in IDLE. `busy` = 1 in every non-IDLE state.

Request checks, made in IDLE at the accept edge:
- Invalid `req_rate` (0, 4–7) or invalid `req_powerdown` (anything other than 0 or 2): pulse `error`, stay in IDLE, no output change.
- Rate change while target PowerDown ≠ 0: pulse `error`, stay in IDLE, no output change.
- Target equals current (Rate = req_rate−1 and PowerDown = req_powerdown): pulse `done`, stay in IDLE, no PHY handshake.

Change sequence:
- Otherwise go to QUIESCE: `TxElecIdle_force` = 1, counter loads `ELECIDLE_SETTLE`.
- QUIESCE counts down to 0. It then goes to APPLY_PD if PowerDown differs, else to APPLY_RATE.
- APPLY_PD: drive `PowerDown` = target for one cycle, then go to WAIT_PD.
- APPLY_RATE: drive `Rate` = req_rate−1 for one cycle, then go to WAIT_RATE.
- WAIT_PD / WAIT_RATE: timeout counter clears on entry.
  - `PhyStatus` = 1 sampled: step complete. From WAIT_PD, go to APPLY_RATE if Rate also differs; otherwise finish.
  - Counter reaches `TIMEOUT_CYCLES` without PhyStatus: pulse `error`, return to IDLE. Already-applied values are kept.

Finish: return to IDLE, pulse `done`, set `TxElecIdle_force` = (PowerDown ≠ 0).

Ignored inputs:
- `PhyStatus` is ignored in IDLE, QUIESCE, APPLY_PD and APPLY_RATE; it produces no done or error.
- A `PhyStatus` that stays high counts once per WAIT state. The WAIT state is entered only after APPLY, so a stale high is never accepted in the same cycle the control changes.

Other rules:
- `done` and `error` are never both 1.
- Reset asserted mid-sequence: immediate return to reset values; the pending request is dropped with no pulse.

## Timing
For a request accepted at edge N, with S = `ELECIDLE_SETTLE`:
- Cycle N+1: state QUIESCE, `busy` = 1, `req_ready` = 0.
- Cycles N+1..N+S: QUIESCE.
- Cycle N+S+1: APPLY (new `PowerDown` or `Rate` visible).
- From cycle N+S+2: WAIT.
- PhyStatus sampled high in cycle M: next APPLY, or `done` and IDLE, at cycle M+1.
- PD-then-rate sequence: second APPLY at M+1, WAIT from M+2.
- Minimum single-step latency, accept to `done`: S+3 cycles.
- Timeout: `error` asserted in cycle W+`TIMEOUT_CYCLES`, where W is the first WAIT cycle.
- No-op, invalid and rejected requests: `done`/`error` in cycle N+1.
- Back-to-back: a new request can be accepted in the same cycle `done` is high.

## Test plan
- Reset; request rate=1, pd=0 (from P1); PhyStatus pulse 3 cycles after APPLY_PD → `PowerDown` 2→0 at cycle 10; `done` at cycle 14; `TxElecIdle_force` 1→0 with `done`; `Rate` stays 0.
- From P0/Gen1, request rate=3, pd=0; PhyStatus on the first WAIT cycle → `Rate` = 2; `done` at S+3 = 11 cycles after accept.
- From P1/Gen1, request rate=2, pd=0 → two handshakes in order: PowerDown first, then `Rate` = 1; a single `done` after the second PhyStatus.
- PhyStatus never arrives, `TIMEOUT_CYCLES`=16 → `error` pulse exactly 16 cycles after WAIT entry; no `done`; applied value retained; `req_ready` = 1.
- Request rate=0 → `error` next cycle; rate=2 with pd=2 → `error`; identical request → `done` next cycle; PhyStatus pulses in IDLE/QUIESCE → no effect.
- Assert `reset_n` low during WAIT_RATE → all outputs return to reset values asynchronously; no `done`/`error` after release.

Source files
------------

// File: rtl/pipe_rate_pd_sequencer_if.sv
// pipe_rate_pd_sequencer_if: request/response and PIPE PHY control signals of the rate/powerdown sequencer
interface pipe_rate_pd_sequencer_if;
    logic       req_valid;
    logic [2:0] req_rate;
    logic [3:0] req_powerdown;
    logic       req_ready;
    logic       done;
    logic       error;
    logic       busy;
    logic       PhyStatus;
    logic [1:0] Rate;
    logic [3:0] PowerDown;
    logic       TxElecIdle_force;
    modport master (
        output req_valid, req_rate, req_powerdown, PhyStatus,
        input  req_ready, done, error, busy, Rate, PowerDown, TxElecIdle_force
    );
    modport slave (
        input  req_valid, req_rate, req_powerdown, PhyStatus,
        output req_ready, done, error, busy, Rate, PowerDown, TxElecIdle_force
    );
endinterface

// File: rtl/pipe_rate_pd_sequencer.sv
// pipe_rate_pd_sequencer: quiesces TX, applies PIPE PowerDown then Rate, and completes each PhyStatus handshake with timeout
module pipe_rate_pd_sequencer #(
    parameter int ELECIDLE_SETTLE = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                     pclk,
    input logic                     reset_n,
    pipe_rate_pd_sequencer_if.slave bus
);
    localparam int MAXC = (ELECIDLE_SETTLE > TIMEOUT_CYCLES) ? ELECIDLE_SETTLE : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, QUIESCE, APPLY_PD, WAIT_PD, APPLY_RATE, WAIT_RATE} state_t;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_rate, r_tgt_rate;
    logic [3:0]      r_pd, r_tgt_pd;
    logic            r_force, r_done, r_error;
    logic [1:0]      w_rate;
    logic            w_bad, w_rate_chg, w_reject, w_noop;
    assign w_rate     = bus.req_rate[1:0] - 2'd1;
    assign w_bad      = (bus.req_rate == 3'd0) || bus.req_rate[2] ||
                        (bus.req_powerdown != 4'd0 && bus.req_powerdown != 4'd2);
    assign w_rate_chg = w_rate != r_rate;
    // The PHY only accepts a rate change while in P0
    assign w_reject   = w_bad || (w_rate_chg && bus.req_powerdown != 4'd0);
    assign w_noop     = !w_rate_chg && bus.req_powerdown == r_pd;
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rate     <= 2'd0;
            r_pd       <= 4'd2;
            r_tgt_rate <= 2'd0;
            r_tgt_pd   <= 4'd0;
            r_force    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    if (w_reject) r_error <= 1'b1;
                    else if (w_noop) r_done <= 1'b1;
                    else begin
                        r_state    <= QUIESCE;
                        r_force    <= 1'b1;
                        r_cnt      <= CW'(ELECIDLE_SETTLE);
                        r_tgt_rate <= w_rate;
                        r_tgt_pd   <= bus.req_powerdown;
                    end
                end
                QUIESCE: if (r_cnt == CW'(1)) begin
                    r_cnt <= '0;
                    if (r_tgt_pd != r_pd) begin
                        r_state <= APPLY_PD;
                        r_pd    <= r_tgt_pd;
                    end else begin
                        r_state <= APPLY_RATE;
                        r_rate  <= r_tgt_rate;
                    end
                end else r_cnt <= r_cnt - CW'(1);
                APPLY_PD: begin
                    r_state <= WAIT_PD;
                    r_cnt   <= '0;
                end
                APPLY_RATE: begin
                    r_state <= WAIT_RATE;
                    r_cnt   <= '0;
                end
                WAIT_PD, WAIT_RATE: if (bus.PhyStatus) begin
                    if (r_state == WAIT_PD && r_tgt_rate != r_rate) begin
                        r_state <= APPLY_RATE;
                        r_rate  <= r_tgt_rate;
                    end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_force <= r_pd != 4'd0;
                    end
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= IDLE;
                    r_error <= 1'b1;
                end else r_cnt <= r_cnt + CW'(1);
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready        = r_state == IDLE;
    assign bus.busy             = r_state != IDLE;
    assign bus.done             = r_done;
    assign bus.error            = r_error;
    assign bus.Rate             = r_rate;
    assign bus.PowerDown        = r_pd;
    assign bus.TxElecIdle_force = r_force;
endmodule

// File: tb/tb_pipe_rate_pd_sequencer.sv
// tb_pipe_rate_pd_sequencer: directed checks of the PIPE rate/powerdown sequencer (S=8, timeout=16)
module tb_pipe_rate_pd_sequencer;
    logic pclk, reset_n;
    int   checks = 0;
    int   errors = 0;
    pipe_rate_pd_sequencer_if bus ();
    pipe_rate_pd_sequencer #(.ELECIDLE_SETTLE(8), .TIMEOUT_CYCLES(16)) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [2:0] rate, input logic [3:0] pd);
        bus.req_valid     = 1'b1;
        bus.req_rate      = rate;
        bus.req_powerdown = pd;
        tick();
        bus.req_valid     = 1'b0;
        bus.req_rate      = 3'd7;
        bus.req_powerdown = 4'hF;
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask
    initial begin
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rate = 3'd0;
        bus.req_powerdown = 4'd0;
        bus.PhyStatus = 1'b0;
        tick(2);
        chk("rst_rate", 32'(bus.Rate), 0);
        chk("rst_pd", 32'(bus.PowerDown), 2);
        chk("rst_force", 32'(bus.TxElecIdle_force), 1);
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_error", 32'(bus.error), 0);
        reset_n = 1'b1;
        tick();
        // P1 -> P0 at Gen1, PhyStatus three cycles after APPLY_PD
        req(3'd1, 4'd0);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_ready", 32'(bus.req_ready), 0);
        chk("t1_pd_q1", 32'(bus.PowerDown), 2);
        tick(7);
        chk("t1_pd_q8", 32'(bus.PowerDown), 2);
        tick();
        chk("t1_pd_apply", 32'(bus.PowerDown), 0);
        chk("t1_rate_apply", 32'(bus.Rate), 0);
        chk("t1_force_apply", 32'(bus.TxElecIdle_force), 1);
        tick(3);
        chk("t1_nodone_wait", 32'(bus.done), 0);
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_error", 32'(bus.error), 0);
        chk("t1_force", 32'(bus.TxElecIdle_force), 0);
        chk("t1_rate", 32'(bus.Rate), 0);
        chk("t1_ready", 32'(bus.req_ready), 1);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 0);
        // Gen1 -> Gen3 at P0, PhyStatus on first WAIT cycle
        req(3'd3, 4'd0);
        tick(8);
        chk("t2_rate_apply", 32'(bus.Rate), 2);
        chk("t2_force_apply", 32'(bus.TxElecIdle_force), 1);
        tick();
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_rate", 32'(bus.Rate), 2);
        chk("t2_force", 32'(bus.TxElecIdle_force), 0);
        tick();
        // P1/Gen1 -> P0/Gen2: two handshakes, one done
        do_reset();
        req(3'd2, 4'd0);
        tick(8);
        chk("t3_pd_apply", 32'(bus.PowerDown), 0);
        chk("t3_rate_hold", 32'(bus.Rate), 0);
        tick(2);
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t3_rate_apply", 32'(bus.Rate), 1);
        chk("t3_nodone_mid", 32'(bus.done), 0);
        chk("t3_busy_mid", 32'(bus.busy), 1);
        tick();
        chk("t3_nodone_wait", 32'(bus.done), 0);
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_rate", 32'(bus.Rate), 1);
        chk("t3_pd", 32'(bus.PowerDown), 0);
        chk("t3_force", 32'(bus.TxElecIdle_force), 0);
        tick();
        // Gen2 -> Gen1 with no PhyStatus: timeout 16 cycles after WAIT entry
        req(3'd1, 4'd0);
        tick(8);
        chk("t4_rate_apply", 32'(bus.Rate), 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t4_wait_noerr", 32'(bus.error), 0);
            tick();
        end
        chk("t4_error", 32'(bus.error), 1);
        chk("t4_nodone", 32'(bus.done), 0);
        chk("t4_ready", 32'(bus.req_ready), 1);
        chk("t4_rate_kept", 32'(bus.Rate), 0);
        tick();
        chk("t4_error_pulse", 32'(bus.error), 0);
        // Rejections, no-op, back-to-back, ignored PhyStatus
        req(3'd0, 4'd0);
        chk("t5_rate0_err", 32'(bus.error), 1);
        chk("t5_rate0_done", 32'(bus.done), 0);
        chk("t5_rate0_busy", 32'(bus.busy), 0);
        req(3'd2, 4'd2);
        chk("t5_rate_p1_err", 32'(bus.error), 1);
        chk("t5_rate_p1_rate", 32'(bus.Rate), 0);
        req(3'd1, 4'd1);
        chk("t5_pd1_err", 32'(bus.error), 1);
        req(3'd5, 4'd0);
        chk("t5_rate5_err", 32'(bus.error), 1);
        req(3'd1, 4'd0);
        chk("t5_noop_done", 32'(bus.done), 1);
        chk("t5_noop_err", 32'(bus.error), 0);
        chk("t5_noop_ready", 32'(bus.req_ready), 1);
        req(3'd1, 4'd0);
        chk("t5_b2b_done", 32'(bus.done), 1);
        tick();
        bus.PhyStatus = 1'b1;
        tick(2);
        chk("t5_idle_phy_done", 32'(bus.done), 0);
        chk("t5_idle_phy_err", 32'(bus.error), 0);
        chk("t5_idle_phy_busy", 32'(bus.busy), 0);
        bus.PhyStatus = 1'b0;
        req(3'd1, 4'd2);
        bus.PhyStatus = 1'b1;
        tick(3);
        bus.PhyStatus = 1'b0;
        chk("t5_q_phy_done", 32'(bus.done), 0);
        chk("t5_q_phy_busy", 32'(bus.busy), 1);
        tick(5);
        chk("t5_pd_apply", 32'(bus.PowerDown), 2);
        tick(3);
        chk("t5_wait_nodone", 32'(bus.done), 0);
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_force", 32'(bus.TxElecIdle_force), 1);
        tick();
        // Asynchronous reset during WAIT_RATE
        do_reset();
        req(3'd2, 4'd0);
        tick(9);
        bus.PhyStatus = 1'b1;
        tick();
        bus.PhyStatus = 1'b0;
        chk("t6_rate_apply", 32'(bus.Rate), 1);
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("t6_rst_rate", 32'(bus.Rate), 0);
        chk("t6_rst_pd", 32'(bus.PowerDown), 2);
        chk("t6_rst_force", 32'(bus.TxElecIdle_force), 1);
        chk("t6_rst_ready", 32'(bus.req_ready), 1);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.PhyStatus = (i == 3);
            tick();
            chk("t6_post_done", 32'(bus.done), 0);
            chk("t6_post_err", 32'(bus.error), 0);
        end
        bus.PhyStatus = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
